div_driver: RTL

DIV_DRIVER -- requirements
Module: div_driver

---
 rtl/div_pkg.sv | 6 +
 rtl/div_result_fifo.sv | 39 +++
 rtl/div_driver.sv | 80 ++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: defaults and constants shared by div_driver and the external divider.
package div_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int PIPELINE_DEF = 4;
    localparam logic [DATA_WIDTH_DEF-1:0] DIV_ZERO_QUOTIENT = '1;
endpackage

// File: rtl/div_result_fifo.sv
// div_result_fifo: power-of-two circular result buffer with occupancy count.
module div_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/div_driver.sv
// div_driver: credit-based wrapper around an external fixed-latency divider; DIV_ZERO_CHECK_EN adds divide-by-zero override.
module div_driver
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PIPELINE = PIPELINE_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_numer,
    input  logic [DATA_WIDTH-1:0] in_denom,
    output logic [DATA_WIDTH-1:0] div_numer,
    output logic [DATA_WIDTH-1:0] div_denom,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic [DATA_WIDTH-1:0] div_remain,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_quotient,
    output logic [DATA_WIDTH-1:0] out_remain,
    output logic                  out_div_zero
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [PIPELINE:0] tag;
    logic [CW-1:0] fifo_count;
    logic accept, fifo_empty, fifo_full_unused;
    // Every tag already owns a FIFO slot, so results can never be dropped.
    assign in_ready = 32'($countones(tag)) + 32'(fifo_count) < 32'(FIFO_DEPTH);
    assign accept = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tag <= '0;
            div_numer <= '0;
            div_denom <= '0;
        end else begin
            tag <= {tag[PIPELINE-1:0], accept};
            if (accept) begin
                div_numer <= in_numer;
                div_denom <= in_denom;
            end
        end
    end
`ifdef DIV_ZERO_CHECK_EN
    localparam int RW = 2*DATA_WIDTH + 1;
    logic [PIPELINE:0] zero_pipe;
    logic [DATA_WIDTH-1:0] numer_pipe [PIPELINE+1];
    logic [RW-1:0] wr_data, rd_data;
    always_ff @(posedge clock) begin
        zero_pipe <= {zero_pipe[PIPELINE-1:0], in_denom == '0};
        numer_pipe[0] <= in_numer;
        for (int i = 1; i <= PIPELINE; i++) numer_pipe[i] <= numer_pipe[i-1];
    end
    assign wr_data = zero_pipe[PIPELINE] ? {{DATA_WIDTH{DIV_ZERO_QUOTIENT[0]}}, numer_pipe[PIPELINE], 1'b1}
                                         : {div_quotient, div_remain, 1'b0};
    assign out_quotient = rd_data[RW-1 -: DATA_WIDTH];
    assign out_remain = rd_data[DATA_WIDTH -: DATA_WIDTH];
    assign out_div_zero = !fifo_empty && rd_data[0];
`else
    localparam int RW = 2*DATA_WIDTH;
    logic [RW-1:0] wr_data, rd_data;
    assign wr_data = {div_quotient, div_remain};
    assign out_quotient = rd_data[RW-1 -: DATA_WIDTH];
    assign out_remain = rd_data[DATA_WIDTH-1:0];
    assign out_div_zero = 1'b0;
`endif
    div_result_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .rst_n   (rst_n),
        .push    (tag[PIPELINE]),
        .pop     (out_ready),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .full    (fifo_full_unused),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );
endmodule
